// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised synchronous up/down counter.
// - Programmable modulus: the count range is 0..mod_limit.
// - Synchronous clear and parallel load.
// - 74169-style P/T enables with an active-low ripple-carry output for cascading.
// - Registered one-cycle wrap pulse and a sticky wrap flag.
module updown_counter_mod #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_b,
    input  logic             load_b,
    input  logic             enp_b,
    input  logic             ent_b,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] mod_limit,
    output logic [WIDTH-1:0] q,
    output logic             rco_b,
    output logic             wrap_pulse,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_pulse_q;
    logic             wrap_pulse_d;
    logic             wrapped_q;
    logic             wrapped_d;
    logic             count_en_s;
    logic             at_top_s;
    logic             at_bottom_s;
    logic             terminal_s;

    // Terminal detection. Values above mod_limit count as terminal when
    // counting up, so an out-of-range value recovers to 0 on the next count.
    always_comb begin
        at_top_s    = (count_q >= mod_limit);
        at_bottom_s = (count_q == ZERO);
        if (up_dn) begin
            terminal_s = at_top_s;
        end else begin
            terminal_s = at_bottom_s;
        end
    end

    // Both enables must be low to count; enp_b deliberately does not reach rco_b.
    assign count_en_s = ~enp_b & ~ent_b;

    // Next-state selection: clear beats load, and load beats count.
    always_comb begin
        count_d      = count_q;
        wrap_pulse_d = 1'b0;
        wrapped_d    = wrapped_q;
        if (!clr_b) begin
            count_d   = ZERO;
            wrapped_d = 1'b0;
        end else if (!load_b) begin
            count_d = d;
        end else if (count_en_s) begin
            if (up_dn) begin
                if (at_top_s) begin
                    count_d      = ZERO;
                    wrap_pulse_d = 1'b1;
                    wrapped_d    = 1'b1;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (at_bottom_s) begin
                    count_d      = mod_limit;
                    wrap_pulse_d = 1'b1;
                    wrapped_d    = 1'b1;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // State and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= RESET_VALUE;
            wrap_pulse_q <= 1'b0;
            wrapped_q    <= 1'b0;
        end else begin
            count_q      <= count_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrapped_q    <= wrapped_d;
        end
    end

    assign q          = count_q;
    assign wrap_pulse = wrap_pulse_q;
    assign wrapped    = wrapped_q;

    // The carry stays combinational so a chain of stages settles within one
    // clock: each stage adds only one gate of depth.
    assign rco_b = ~(~ent_b & terminal_s);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench for updown_counter_mod.
// A behavioural model tracks the main 8-bit instance on every cycle.
// Directed sequences pin literal expectations.
// A two-stage 4-bit cascade is checked against a plain edge count.
module tb_updown_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst       = 1'b1;
    logic       clr_b     = 1'b1;
    logic       load_b    = 1'b1;
    logic       enp_b     = 1'b1;
    logic       ent_b     = 1'b1;
    logic       up_dn     = 1'b1;
    logic [7:0] d         = 8'h00;
    logic [7:0] mod_limit = 8'hFF;
    logic [7:0] q;
    logic       rco_b;
    logic       wrap_pulse;
    logic       wrapped;

    updown_counter_mod #(.WIDTH(8), .RESET_VALUE(8'h05)) dut (
        .clk(clk), .rst(rst), .clr_b(clr_b), .load_b(load_b), .enp_b(enp_b),
        .ent_b(ent_b), .up_dn(up_dn), .d(d), .mod_limit(mod_limit),
        .q(q), .rco_b(rco_b), .wrap_pulse(wrap_pulse), .wrapped(wrapped)
    );

    // Two-stage cascade: the low stage's carry feeds the high stage's ent_b.
    logic       c_clr_b = 1'b1;
    logic       c_enp_b = 1'b1;
    logic       c_up_dn = 1'b1;
    logic [3:0] c_lo_q;
    logic [3:0] c_hi_q;
    logic       c_lo_rco;
    logic       c_hi_rco;
    logic       c_lo_wp;
    logic       c_lo_w;
    logic       c_hi_wp;
    logic       c_hi_w;

    updown_counter_mod #(.WIDTH(4), .RESET_VALUE(4'h0)) u_lo (
        .clk(clk), .rst(rst), .clr_b(c_clr_b), .load_b(1'b1), .enp_b(c_enp_b),
        .ent_b(1'b0), .up_dn(c_up_dn), .d(4'h0), .mod_limit(4'hF),
        .q(c_lo_q), .rco_b(c_lo_rco), .wrap_pulse(c_lo_wp), .wrapped(c_lo_w)
    );
    updown_counter_mod #(.WIDTH(4), .RESET_VALUE(4'h0)) u_hi (
        .clk(clk), .rst(rst), .clr_b(c_clr_b), .load_b(1'b1), .enp_b(c_enp_b),
        .ent_b(c_lo_rco), .up_dn(c_up_dn), .d(4'h0), .mod_limit(4'hF),
        .q(c_hi_q), .rco_b(c_hi_rco), .wrap_pulse(c_hi_wp), .wrapped(c_hi_w)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model of the main instance, in plain integers.
    int m_q       = 5;
    int m_pulse   = 0;
    int m_wrapped = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Model update: compute the next state directly from the counter's rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= 5;
            m_pulse   <= 0;
            m_wrapped <= 0;
        end else if (!clr_b) begin
            m_q       <= 0;
            m_pulse   <= 0;
            m_wrapped <= 0;
        end else if (!load_b) begin
            m_q     <= int'(d);
            m_pulse <= 0;
        end else if (!enp_b && !ent_b) begin
            if (up_dn && m_q >= int'(mod_limit)) begin
                m_q <= 0;       m_pulse <= 1; m_wrapped <= 1;
            end else if (up_dn) begin
                m_q <= m_q + 1; m_pulse <= 0;
            end else if (m_q == 0) begin
                m_q <= int'(mod_limit); m_pulse <= 1; m_wrapped <= 1;
            end else begin
                m_q <= m_q - 1; m_pulse <= 0;
            end
        end else begin
            m_pulse <= 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            int exp_rco;
            exp_rco = (!ent_b && (up_dn ? (m_q >= int'(mod_limit)) : (m_q == 0))) ? 0 : 1;
            check("model_q", int'(q), m_q);
            check("model_wrap_pulse", int'(wrap_pulse), m_pulse);
            check("model_wrapped", int'(wrapped), m_wrapped);
            check("model_rco_b", int'(rco_b), exp_rco);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_seq[3];
        int exp_pls[3];
        int exp_rco[3];

        // Reset held across edges, then released away from an edge.
        repeat (2) @(posedge clk);
        #1;
        check("reset_q", int'(q), 8'h05);
        check("reset_wrapped", int'(wrapped), 0);
        check("reset_rco_b", int'(rco_b), 1);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Modulo-10 up-count from 0.
        clr_b = 1'b0;
        tick();
        check("clear_q", int'(q), 0);
        clr_b = 1'b1; mod_limit = 8'd9; up_dn = 1'b1; enp_b = 1'b0; ent_b = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            int e;
            e = i % 10;
            tick();
            check("up_q", int'(q), e);
            check("up_pulse", int'(wrap_pulse), (e == 0) ? 1 : 0);
            check("up_rco_b", int'(rco_b), (e == 9) ? 0 : 1);
            check("up_wrapped", int'(wrapped), (i >= 10) ? 1 : 0);
        end

        // Down-count through the wrap.
        up_dn = 1'b0; load_b = 1'b0; d = 8'd1;
        tick();
        check("down_load_q", int'(q), 1);
        load_b = 1'b1;
        exp_seq = '{0, 9, 8};
        exp_pls = '{0, 1, 0};
        exp_rco = '{0, 1, 1};
        for (int i = 0; i < 3; i++) begin
            tick();
            check("down_q", int'(q), exp_seq[i]);
            check("down_pulse", int'(wrap_pulse), exp_pls[i]);
            check("down_rco_b", int'(rco_b), exp_rco[i]);
        end

        // Priority: clear over load over count.
        clr_b = 1'b0; load_b = 1'b0; d = 8'h33; up_dn = 1'b1;
        tick();
        check("prio_clr_q", int'(q), 0);
        check("prio_clr_wrapped", int'(wrapped), 0);
        clr_b = 1'b1;
        tick();
        check("prio_load_q", int'(q), 8'h33);
        load_b = 1'b1; enp_b = 1'b1;
        tick();
        check("prio_hold_q", int'(q), 8'h33);
        check("prio_hold_rco_b", int'(rco_b), 0);

        // Out-of-range loads and the extreme modulus.
        enp_b = 1'b0; load_b = 1'b0; d = 8'h0C;
        tick();
        check("oor_load_q", int'(q), 8'h0C);
        load_b = 1'b1;
        tick();
        check("oor_up_q", int'(q), 0);
        check("oor_up_pulse", int'(wrap_pulse), 1);
        load_b = 1'b0;
        tick();
        load_b = 1'b1; up_dn = 1'b0;
        tick();
        check("oor_down_q", int'(q), 8'h0B);
        check("oor_down_pulse", int'(wrap_pulse), 0);
        mod_limit = 8'd0; up_dn = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mod0_q", int'(q), 0);
            check("mod0_pulse", int'(wrap_pulse), 1);
            check("mod0_rco_b", int'(rco_b), 0);
        end
        ent_b = 1'b1;
        #1;
        check("mod0_rco_follows_ent", int'(rco_b), 1);
        ent_b = 1'b0;

        // Asynchronous reset asserted in the middle of a cycle.
        mod_limit = 8'd9;
        tick();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_q", int'(q), 8'h05);
        check("async_rst_wrapped", int'(wrapped), 0);
        check("async_rst_pulse", int'(wrap_pulse), 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_q", int'(q), 6);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            clr_b  = ($urandom_range(0, 15) != 0);
            load_b = ($urandom_range(0, 7) != 0);
            enp_b  = ($urandom_range(0, 4) == 0);
            ent_b  = ($urandom_range(0, 4) == 0);
            up_dn  = 1'($urandom_range(0, 1));
            d      = 8'($urandom);
            if (i % 40 == 0) begin
                case ($urandom_range(0, 4))
                    0:       mod_limit = 8'd0;
                    1:       mod_limit = 8'd1;
                    2:       mod_limit = 8'd9;
                    3:       mod_limit = 8'hFF;
                    default: mod_limit = 8'($urandom);
                endcase
            end
            tick();
        end
        clr_b = 1'b1; load_b = 1'b1; enp_b = 1'b1;

        // Cascade: up 300 edges from 0, then one down edge from 0.
        c_clr_b = 1'b0;
        tick();
        c_clr_b = 1'b1; c_enp_b = 1'b0; c_up_dn = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            check("cascade_up", int'({c_hi_q, c_lo_q}), i % 256);
        end
        c_clr_b = 1'b0;
        tick();
        check("cascade_clear", int'({c_hi_q, c_lo_q}), 0);
        c_clr_b = 1'b1; c_up_dn = 1'b0;
        tick();
        check("cascade_down", int'({c_hi_q, c_lo_q}), 8'hFF);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
